// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver (LSB first) that pushes good bytes into the RX fifo.
// Define UART_RX_PARITY_EN to add one even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int unsigned B       = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned DVSR    = 163
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  input  logic         full,
  output logic         wr,
  output logic [B-1:0] dout,
  output logic         busy,
  output logic         frame_err,
  output logic         overrun,
  output logic         parity_err
);

  localparam int unsigned CNT_W = (DVSR > 2) ? $clog2(DVSR) : 1;
  localparam int unsigned S_W   = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned N_W   = (B > 2) ? $clog2(B) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DVSR - 1);
  localparam logic [S_W-1:0]   S_MID      = S_W'(7);
  localparam logic [S_W-1:0]   S_BIT_END  = S_W'(15);
  localparam logic [S_W-1:0]   S_STOP_END = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0]   N_LAST     = N_W'(B - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer and oversample tick
  // ---------------------------------------------------------------------------
  logic             rx_meta_q;
  logic             rx_s;
  logic [CNT_W-1:0] cnt_q;
  logic             tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep these two flops a real two-stage chain;
      // blocking ones would collapse the synchronizer into a single flop.
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: state register
  // ---------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [S_W-1:0] s_q, s_d;
  logic [N_W-1:0] n_q, n_d;
  logic [B-1:0]   sh_q, sh_d;
  logic           par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      sh_q      <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      sh_q      <= sh_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves one unassigned
    // and no latch is inferred.
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    sh_d      = sh_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            // A start bit still low at mid-bit is real; otherwise it was a glitch.
            if (!rx_s) begin
              state_d   = DATA;
              s_d       = '0;
              n_d       = '0;
`ifdef UART_RX_PARITY_EN
              par_bad_d = 1'b0;
`endif
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_BIT_END) begin
            s_d  = '0;
            sh_d = {rx_s, sh_q[B-1:1]};
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == S_BIT_END) begin
            s_d       = '0;
            par_bad_d = (^sh_q) ^ rx_s;
            state_d   = STOP;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_q == S_STOP_END) begin
            state_d = IDLE;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: output decode
  // ---------------------------------------------------------------------------
  logic eval;
  logic wr_d, frame_err_d, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic parity_err_d;
`endif

  always_comb begin
    busy         = (state_q != IDLE);
    eval         = (state_q == STOP) && tick && (s_q == S_STOP_END);
    // Priority: bad stop bit, then bad parity, then fifo full.
    frame_err_d  = eval && !rx_s;
    wr_d         = eval && rx_s && !par_bad && !full;
    overrun_d    = eval && rx_s && !par_bad && full;
`ifdef UART_RX_PARITY_EN
    parity_err_d = eval && rx_s && par_bad;
`endif
  end

  // Evaluation results land one clk after the final stop tick.
  logic         wr_q, frame_err_q, overrun_q;
  logic [B-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q        <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // NOTE: dout is reset along with the control flops, so a reset mid-frame can
      // never expose a stale or partial byte.
      dout_q      <= '0;
    end else begin
      wr_q        <= wr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      if (wr_d) begin
        dout_q <= sh_q;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign wr        = wr_q;
  assign dout      = dout_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
